// File: rtl/uart_pkg.sv
// Shared types and constants for the UART buffering stage.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        ACK,
        DRAIN
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit occupancy count.
// Flags overrun (dropped push) and underrun (pop while empty) as single-cycle pulses.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overrun,
    output logic                    underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push, do_pop;

    always_comb begin
        count    = wr_q - rd_q;
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop && !empty;
        // A full FIFO still accepts a push when the same cycle frees a slot.
        do_push  = push && (!full || do_pop);
        overrun  = push && !do_push;
        underrun = pop && empty;
        rdata    = empty ? '0 : mem_q[rd_q[AW-1:0]];
        wr_d     = wr_q + CW'(do_push);
        rd_d     = rd_q + CW'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/uart_buffer_ctrl.sv
// UART RX/TX buffering, TX launch pacing, RTS/CTS flow control and sticky status.
// Optional irq output enabled by defining UART_BUF_IRQ_EN.
//   state  | meaning
//   IDLE   | waiting for a queued word, cts_s high and engine not busy
//   LAUNCH | tx_valid pulse for the word just popped into tx_data
//   ACK    | waiting for the engine to raise tx_busy
//   DRAIN  | waiting for the engine to drop tx_busy
module uart_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int RTS_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_done,
    input  logic                    rx_err,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_busy,
    input  logic                    cts,
    output logic                    rts,
    input  logic [DATA_W-1:0]       host_wdata,
    input  logic                    host_wen,
    output logic [DATA_W-1:0]       host_rdata,
    input  logic                    host_ren,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic                    rx_empty,
    output logic                    tx_full,
    output logic                    err_overrun,
    output logic                    err_underrun,
    output logic                    err_frame,
    input  logic                    err_clear
`ifdef UART_BUF_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam logic RTS_RST = (RTS_MARGIN >= DEPTH);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
        $error("uart_buffer_ctrl: DATA_W out of range");
    end

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, tx_head;
    logic              cts_meta_q, cts_s_q;
    logic              rts_q, rts_d;
    logic              err_ovr_q, err_ovr_d, err_und_q, err_und_d, err_frm_q, err_frm_d;
    logic              tx_pop, tx_empty, rx_full;
    logic              rx_ovr, rx_und, tx_ovr, tx_und;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .nReset(nReset),
        .push(rx_done && !rx_err), .wdata(rx_data), .pop(host_ren),
        .rdata(host_rdata), .count(rx_count), .full(rx_full), .empty(rx_empty),
        .overrun(rx_ovr), .underrun(rx_und)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .nReset(nReset),
        .push(host_wen), .wdata(host_wdata), .pop(tx_pop),
        .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty),
        .overrun(tx_ovr), .underrun(tx_und)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        tx_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && cts_s_q && !tx_busy) begin
                    state_d   = LAUNCH;
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                end
            end
            LAUNCH: begin
                tx_valid = 1'b1;
                state_d  = ACK;
            end
            ACK:     if (tx_busy)  state_d = DRAIN;
            DRAIN:   if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_ovr_d = err_ovr_q || rx_ovr || tx_ovr;
        err_und_d = err_und_q || rx_und || tx_und;
        err_frm_d = err_frm_q || (rx_done && rx_err);
        if (err_clear) begin
            err_ovr_d = 1'b0;
            err_und_d = 1'b0;
            err_frm_d = 1'b0;
        end
        rts_d = rx_full || ((DEPTH - int'(rx_count)) <= RTS_MARGIN);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            cts_meta_q <= 1'b0;
            cts_s_q    <= 1'b0;
            rts_q      <= RTS_RST;
            err_ovr_q  <= 1'b0;
            err_und_q  <= 1'b0;
            err_frm_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            cts_meta_q <= cts;
            cts_s_q    <= cts_meta_q;
            rts_q      <= rts_d;
            err_ovr_q  <= err_ovr_d;
            err_und_q  <= err_und_d;
            err_frm_q  <= err_frm_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign rts          = rts_q;
    assign err_overrun  = err_ovr_q;
    assign err_underrun = err_und_q;
    assign err_frame    = err_frm_q;

`ifdef UART_BUF_IRQ_EN
    logic txe_flag_q, txe_flag_d, irq_q, irq_d;

    // The TX-empty term arms on a launch and disarms on the next host write.
    always_comb begin
        txe_flag_d = tx_pop ? 1'b1 : (host_wen ? 1'b0 : txe_flag_q);
        irq_d      = (int'(rx_count) >= DEPTH / 2) || (txe_flag_q && tx_empty)
                     || err_ovr_q || err_und_q || err_frm_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            txe_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            txe_flag_q <= txe_flag_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_buffer_ctrl.sv
// Self-checking bench for uart_buffer_ctrl: directed scenarios plus a randomized RX run
// against a queue-based reference model.
module tb_uart_buffer_ctrl;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 8;
    localparam int RTS_MARGIN = 2;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              nReset;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done, rx_err;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid, tx_busy, cts, rts;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              host_wen, host_ren;
    logic [CW-1:0]     rx_count, tx_count;
    logic              rx_empty, tx_full;
    logic              err_overrun, err_underrun, err_frame, err_clear;
`ifdef UART_BUF_IRQ_EN
    logic              irq;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] tx_q[$];

    uart_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RTS_MARGIN(RTS_MARGIN)) dut (
        .clk(clk), .nReset(nReset),
        .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .cts(cts), .rts(rts),
        .host_wdata(host_wdata), .host_wen(host_wen),
        .host_rdata(host_rdata), .host_ren(host_ren),
        .rx_count(rx_count), .tx_count(tx_count),
        .rx_empty(rx_empty), .tx_full(tx_full),
        .err_overrun(err_overrun), .err_underrun(err_underrun), .err_frame(err_frame),
        .err_clear(err_clear)
`ifdef UART_BUF_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rx_done = 0; rx_err = 0; rx_data = '0; tx_busy = 0; cts = 0;
        host_wen = 0; host_wdata = '0; host_ren = 0; err_clear = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        nReset = 0;
        #3;
        @(posedge clk);
        #1 nReset = 1;
        tick();
        rx_q.delete();
        tx_q.delete();
    endtask

    task automatic rx_push(input logic [DATA_W-1:0] d, input logic e);
        rx_data = d; rx_err = e; rx_done = 1;
        tick();
        rx_done = 0; rx_err = 0;
    endtask

    task automatic host_write(input logic [DATA_W-1:0] d);
        host_wdata = d; host_wen = 1;
        tick();
        host_wen = 0;
    endtask

    task automatic host_read();
        host_ren = 1;
        tick();
        host_ren = 0;
    endtask

    task automatic pulse_clear();
        err_clear = 1;
        tick();
        err_clear = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        nReset = 0;
        #2;
        checks++;
        if ({tx_valid, tx_data, host_rdata, rx_count, tx_count, tx_full} !== '0)
            begin failures++; $display("FAIL reset_zero: outputs=%h required 0",
                {tx_valid, tx_data, host_rdata, rx_count, tx_count, tx_full}); end
        checks++;
        if ({err_overrun, err_underrun, err_frame} !== 3'b000)
            begin failures++; $display("FAIL reset_errs: got %b required 000",
                {err_overrun, err_underrun, err_frame}); end
        checks++;
        if (rx_empty !== 1'b1 || rts !== 1'b0)
            begin failures++; $display("FAIL reset_flags: rx_empty=%b rts=%b required 1 0",
                rx_empty, rts); end
`ifdef UART_BUF_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
        @(posedge clk);
        #1 nReset = 1;
        tick();
    endtask

    task automatic test_rx_ordering();
        apply_reset();
        rx_push(8'h55, 0);
        rx_push(8'hA3, 0);
        checks++;
        if (rx_count !== CW'(2) || host_rdata !== 8'h55)
            begin failures++; $display("FAIL rx_order_first: count=%0d rdata=%h required 2 55",
                rx_count, host_rdata); end
        host_read();
        checks++;
        if (rx_count !== CW'(1) || host_rdata !== 8'hA3)
            begin failures++; $display("FAIL rx_order_second: count=%0d rdata=%h required 1 a3",
                rx_count, host_rdata); end
        host_read();
        checks++;
        if (rx_empty !== 1'b1 || err_underrun !== 1'b0)
            begin failures++; $display("FAIL rx_order_empty: empty=%b und=%b required 1 0",
                rx_empty, err_underrun); end
    endtask

    task automatic test_rx_overrun();
        logic [DATA_W-1:0] words[9];
        int prev;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            words[i] = DATA_W'($urandom);
            prev = (i < DEPTH) ? i : DEPTH;
            rx_push(words[i], 0);
            checks++;
            if (rts !== ((DEPTH - prev) <= RTS_MARGIN))
                begin failures++; $display("FAIL rts_step%0d: got %b required %b",
                    i + 1, rts, ((DEPTH - prev) <= RTS_MARGIN)); end
        end
        checks++;
        if (rx_count !== CW'(DEPTH) || err_overrun !== 1'b1)
            begin failures++; $display("FAIL rx_overrun: count=%0d ovr=%b required 8 1",
                rx_count, err_overrun); end
        tick();
        checks++;
        if (rts !== 1'b1) begin failures++; $display("FAIL rts_full: got %b required 1", rts); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (host_rdata !== words[i])
                begin failures++; $display("FAIL rx_drain%0d: got %h required %h",
                    i, host_rdata, words[i]); end
            host_read();
        end
        checks++;
        if (rx_empty !== 1'b1) begin failures++; $display("FAIL ninth_absent: rx_empty=%b", rx_empty); end
    endtask

    task automatic test_tx_cts();
        int pulses;
        int first;
        apply_reset();
        repeat (3) tick();
        host_write(8'h41);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || tx_count !== CW'(1))
            begin failures++; $display("FAIL cts_block: pulses=%0d count=%0d required 0 1",
                pulses, tx_count); end
        cts = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (tx_valid !== (k == 3))
                begin failures++; $display("FAIL cts_latency_c%0d: tx_valid=%b required %b",
                    k, tx_valid, (k == 3)); end
        end
        checks++;
        if (tx_data !== 8'h41 || tx_count !== CW'(0))
            begin failures++; $display("FAIL tx_first: data=%h count=%0d required 41 0",
                tx_data, tx_count); end
        tx_busy = 1;
        host_write(8'h42);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_single_pulse: tx_valid=%b", tx_valid); end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL tx_busy_hold: pulses=%0d required 0", pulses); end
        tx_busy = 0;
        first = 0;
        for (int k = 1; k <= 10 && first == 0; k++) begin
            tick();
            if (tx_valid) first = k;
        end
        checks++;
        if (first != 2 || tx_data !== 8'h42)
            begin failures++; $display("FAIL tx_second: cycle=%0d data=%h required 2 42",
                first, tx_data); end
        tx_busy = 1;
        tick(); tick();
        tx_busy = 0;
        tick(); tick();
    endtask

    task automatic test_frame_clear();
        pulse_clear();
        checks++;
        if ({err_overrun, err_underrun, err_frame} !== 3'b000)
            begin failures++; $display("FAIL clear_all: got %b required 000",
                {err_overrun, err_underrun, err_frame}); end
        rx_push(8'h3C, 0);
        rx_push(8'h77, 1);
        checks++;
        if (err_frame !== 1'b1 || rx_count !== CW'(1))
            begin failures++; $display("FAIL frame_set: frame=%b count=%0d required 1 1",
                err_frame, rx_count); end
        rx_data = 8'h66; rx_done = 1; rx_err = 1; err_clear = 1;
        tick();
        rx_done = 0; rx_err = 0; err_clear = 0;
        checks++;
        if (err_frame !== 1'b0 || rx_count !== CW'(1) || host_rdata !== 8'h3C)
            begin failures++; $display("FAIL clear_priority: frame=%b count=%0d rdata=%h required 0 1 3c",
                err_frame, rx_count, host_rdata); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] d, exp;
        int got;
        apply_reset();
        repeat (3) tick();
        for (int i = 0; i < DEPTH; i++) begin
            d = DATA_W'($urandom);
            host_write(d);
            tx_q.push_back(d);
        end
        checks++;
        if (tx_count !== CW'(DEPTH) || tx_full !== 1'b1)
            begin failures++; $display("FAIL tx_fill: count=%0d full=%b required 8 1",
                tx_count, tx_full); end
        host_write(8'hEE);
        checks++;
        if (err_overrun !== 1'b1 || tx_count !== CW'(DEPTH))
            begin failures++; $display("FAIL tx_overrun: ovr=%b count=%0d required 1 8",
                err_overrun, tx_count); end
        pulse_clear();
        cts = 1;
        tick(); tick();
        d = DATA_W'($urandom);
        host_wdata = d; host_wen = 1;
        tick();
        host_wen = 0;
        tx_q.push_back(d);
        exp = tx_q.pop_front();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp || tx_count !== CW'(DEPTH) || err_overrun !== 1'b0)
            begin failures++; $display("FAIL full_push_pop: valid=%b data=%h count=%0d ovr=%b required 1 %h 8 0",
                tx_valid, tx_data, tx_count, err_overrun, exp); end
        for (int n = 0; n < DEPTH; n++) begin
            tx_busy = 1;
            repeat ($urandom_range(2, 5)) tick();
            tx_busy = 0;
            got = 0;
            for (int k = 0; k < 20 && got == 0; k++) begin
                tick();
                if (tx_valid) got = 1;
            end
            exp = tx_q.pop_front();
            checks++;
            if (got == 0 || tx_data !== exp)
                begin failures++; $display("FAIL tx_order%0d: launched=%0d data=%h required 1 %h",
                    n, got, tx_data, exp); end
        end
        tx_busy = 1;
        tick(); tick();
        tx_busy = 0;
        tick(); tick();
        checks++;
        if (tx_count !== CW'(0)) begin failures++; $display("FAIL tx_drained: count=%0d required 0", tx_count); end
`ifdef UART_BUF_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty: got %b required 1", irq); end
`endif
    endtask

    task automatic test_random_rx();
        logic m_ovr, m_und, m_frm;
        logic done, err, ren, clr, exp_rts, pop_ok;
        logic [DATA_W-1:0] d, exp_rd;
        int sz, ren_pct;
        apply_reset();
        m_ovr = 0; m_und = 0; m_frm = 0;
        for (int c = 0; c < 400; c++) begin
            ren_pct = ((c / 100) % 2 == 0) ? 15 : 75;
            done = ($urandom_range(0, 99) < 50);
            err  = done && ($urandom_range(0, 9) == 0);
            ren  = ($urandom_range(0, 99) < ren_pct);
            clr  = ($urandom_range(0, 39) == 0);
            d    = DATA_W'($urandom);
            rx_done = done; rx_err = err; rx_data = d; host_ren = ren; err_clear = clr;
            tick();
            rx_done = 0; rx_err = 0; host_ren = 0; err_clear = 0;
            sz = rx_q.size();
            exp_rts = ((DEPTH - sz) <= RTS_MARGIN);
            pop_ok = ren && sz > 0;
            if (pop_ok) void'(rx_q.pop_front());
            if (ren && sz == 0) m_und = 1;
            if (done && err) m_frm = 1;
            if (done && !err) begin
                if (sz == DEPTH && !pop_ok) m_ovr = 1;
                else rx_q.push_back(d);
            end
            if (clr) begin m_ovr = 0; m_und = 0; m_frm = 0; end
            exp_rd = (rx_q.size() > 0) ? rx_q[0] : '0;
            checks++;
            if (rx_count !== CW'(rx_q.size()) || rx_empty !== (rx_q.size() == 0))
                begin failures++; $display("FAIL rand_count c%0d: count=%0d empty=%b required %0d",
                    c, rx_count, rx_empty, rx_q.size()); end
            checks++;
            if (host_rdata !== exp_rd)
                begin failures++; $display("FAIL rand_rdata c%0d: got %h required %h", c, host_rdata, exp_rd); end
            checks++;
            if ({err_overrun, err_underrun, err_frame} !== {m_ovr, m_und, m_frm})
                begin failures++; $display("FAIL rand_errs c%0d: got %b required %b", c,
                    {err_overrun, err_underrun, err_frame}, {m_ovr, m_und, m_frm}); end
            checks++;
            if (rts !== exp_rts)
                begin failures++; $display("FAIL rand_rts c%0d: got %b required %b", c, rts, exp_rts); end
        end
    endtask

    task automatic test_async_reset();
        int got;
        apply_reset();
        cts = 1;
        rx_push(8'h11, 0);
        rx_push(8'h22, 0);
        host_write(8'h99);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            tick();
            if (tx_valid) got = 1;
        end
        checks++;
        if (got == 0) begin failures++; $display("FAIL prereset_launch: no tx_valid within 10 cycles"); end
        tick();
        #3 nReset = 0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== '0 || rx_count !== '0 || tx_count !== '0 || rx_empty !== 1'b1)
            begin failures++; $display("FAIL async_reset: valid=%b data=%h rxc=%0d txc=%0d empty=%b required 0 00 0 0 1",
                tx_valid, tx_data, rx_count, tx_count, rx_empty); end
`ifdef UART_BUF_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL async_reset_irq: got %b required 0", irq); end
`endif
        @(posedge clk);
        #1 nReset = 1;
        tick();
        host_write(8'h5A);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            tick();
            if (tx_valid) got = 1;
        end
        checks++;
        if (got == 0 || tx_data !== 8'h5A)
            begin failures++; $display("FAIL postreset_idle: launched=%0d data=%h required 1 5a", got, tx_data); end
    endtask

    initial begin
        test_reset();
        test_rx_ordering();
        test_rx_overrun();
        test_tx_cts();
        test_frame_clear();
        test_full_push_pop();
        test_random_rx();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
